// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan for the dual common-anode display: DIG0, BLANK0, DIG1, BLANK1.
// Both digit values are captured once per frame so a lit digit never changes mid-frame.
module display_scan_ctrl #(
  parameter int ON_CYCLES    = 99000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sA,
  input  logic [3:0] sB,
  output logic [3:0] s,
  output logic [1:0] control,
  output logic       blank,
  output logic       frame_tick
);

  localparam int MAX_CYCLES = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    DIG0   = 2'd0,
    BLANK0 = 2'd1,
    DIG1   = 2'd2,
    BLANK1 = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          last;
  logic          capture;
  logic [3:0]    digA_q;
  logic [3:0]    digB_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= BLANK1;
      cnt    <= '0;
      digA_q <= 4'h0;
      digB_q <= 4'h0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (capture) begin
        digA_q <= sA;
        digB_q <= sB;
      end
    end
  end

  // Capture happens only on the BLANK1->DIG0 edge, so the whole frame shows one snapshot.
  always_comb begin
    state_next = state;
    cnt_next   = cnt + CW'(1);
    capture    = 1'b0;
    last       = 1'b0;
    case (state)
      DIG0, DIG1: last = (cnt == ON_LAST);
      default:    last = (cnt == BLANK_LAST);
    endcase
    if (last) begin
      cnt_next = '0;
      case (state)
        DIG0:    state_next = BLANK0;
        BLANK0:  state_next = DIG1;
        DIG1:    state_next = BLANK1;
        default: begin
          state_next = DIG0;
          capture    = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    control    = 2'b11;
    s          = 4'h0;
    blank      = 1'b1;
    frame_tick = 1'b0;
    case (state)
      DIG0: begin
        control    = 2'b10;
        s          = digA_q;
        blank      = 1'b0;
        frame_tick = (cnt == '0);
      end
      DIG1: begin
        control = 2'b01;
        s       = digB_q;
        blank   = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: a 4/2 instance driven from a vector table,
// plus a 1/1 instance for the minimum-dwell boundary.
module tb_display_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       reset2;
  logic [3:0] sA;
  logic [3:0] sB;
  logic [3:0] s;
  logic [1:0] control;
  logic       blank;
  logic       frame_tick;
  logic [3:0] s2;
  logic [1:0] control2;
  logic       blank2;
  logic       frame_tick2;

  int passCount  = 0;
  int checkCount = 0;

  typedef struct {
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] ctl;
    logic [3:0] sv;
    logic       blk;
    logic       ft;
  } vec_t;

  vec_t vecs[$];

  display_scan_ctrl #(.ON_CYCLES(4), .BLANK_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .sA(sA), .sB(sB),
    .s(s), .control(control), .blank(blank), .frame_tick(frame_tick)
  );

  display_scan_ctrl #(.ON_CYCLES(1), .BLANK_CYCLES(1)) dutMin (
    .clk(clk), .reset(reset2), .sA(sA), .sB(sB),
    .s(s2), .control(control2), .blank(blank2), .frame_tick(frame_tick2)
  );

  always #5 clk = ~clk;

  function automatic void addRun(input int n, input logic rst, input logic [3:0] a,
                                 input logic [3:0] b, input logic [1:0] ctl,
                                 input logic [3:0] sv, input logic blk, input logic ft);
    for (int i = 0; i < n; i++) vecs.push_back('{rst, a, b, ctl, sv, blk, ft});
  endfunction

  task automatic applyStimulus(input logic rst, input logic [3:0] a, input logic [3:0] b);
    reset = rst;
    sA    = a;
    sB    = b;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [1:0] actCtl, input logic [3:0] actS,
                             input logic actBlk, input logic actFt, input logic [1:0] expCtl,
                             input logic [3:0] expS, input logic expBlk, input logic expFt);
    checkCount++;
    if (actCtl !== expCtl || actS !== expS || actBlk !== expBlk || actFt !== expFt)
      $display("[TB] FAIL %s: got control=%b s=%h blank=%b frame_tick=%b, expected control=%b s=%h blank=%b frame_tick=%b",
               name, actCtl, actS, actBlk, actFt, expCtl, expS, expBlk, expFt);
    else
      passCount++;
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    checkCount++;
    if (act != exp) $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    else passCount++;
  endtask

  initial begin
    logic [1:0] eCtl;
    logic [3:0] eS;

    reset  = 1'b0;
    reset2 = 1'b0;
    sA     = 4'h5;
    sB     = 4'hA;

    // Reset, first frame, tear-free change at DIG0 cnt1, then reset in the third DIG1 cycle.
    addRun(3, 1'b0, 4'h5, 4'hA, 2'b11, 4'h0, 1'b1, 1'b0);
    addRun(1, 1'b1, 4'h5, 4'hA, 2'b11, 4'h0, 1'b1, 1'b0);
    addRun(1, 1'b1, 4'h5, 4'hA, 2'b10, 4'h5, 1'b0, 1'b1);
    addRun(3, 1'b1, 4'h5, 4'hA, 2'b10, 4'h5, 1'b0, 1'b0);
    addRun(2, 1'b1, 4'h5, 4'hA, 2'b11, 4'h0, 1'b1, 1'b0);
    addRun(4, 1'b1, 4'h5, 4'hA, 2'b01, 4'hA, 1'b0, 1'b0);
    addRun(2, 1'b1, 4'h5, 4'hA, 2'b11, 4'h0, 1'b1, 1'b0);
    addRun(1, 1'b1, 4'h5, 4'hA, 2'b10, 4'h5, 1'b0, 1'b1);
    addRun(1, 1'b1, 4'h5, 4'hA, 2'b10, 4'h5, 1'b0, 1'b0);
    addRun(2, 1'b1, 4'h3, 4'hA, 2'b10, 4'h5, 1'b0, 1'b0);
    addRun(2, 1'b1, 4'h3, 4'hA, 2'b11, 4'h0, 1'b1, 1'b0);
    addRun(4, 1'b1, 4'h3, 4'hA, 2'b01, 4'hA, 1'b0, 1'b0);
    addRun(2, 1'b1, 4'h3, 4'hA, 2'b11, 4'h0, 1'b1, 1'b0);
    addRun(1, 1'b1, 4'h3, 4'hA, 2'b10, 4'h3, 1'b0, 1'b1);
    addRun(3, 1'b1, 4'h3, 4'hA, 2'b10, 4'h3, 1'b0, 1'b0);
    addRun(2, 1'b1, 4'h3, 4'hA, 2'b11, 4'h0, 1'b1, 1'b0);
    addRun(3, 1'b1, 4'h9, 4'h7, 2'b01, 4'hA, 1'b0, 1'b0);
    addRun(1, 1'b0, 4'h9, 4'h7, 2'b11, 4'h0, 1'b1, 1'b0);
    addRun(1, 1'b1, 4'h9, 4'h7, 2'b11, 4'h0, 1'b1, 1'b0);
    addRun(1, 1'b1, 4'h9, 4'h7, 2'b10, 4'h9, 1'b0, 1'b1);
    addRun(3, 1'b1, 4'h9, 4'h7, 2'b10, 4'h9, 1'b0, 1'b0);
    addRun(2, 1'b1, 4'h9, 4'h7, 2'b11, 4'h0, 1'b1, 1'b0);
    addRun(4, 1'b1, 4'h9, 4'h7, 2'b01, 4'h7, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].a, vecs[i].b);
      checkOutput($sformatf("vec%0d", i), control, s, blank, frame_tick,
                  vecs[i].ctl, vecs[i].sv, vecs[i].blk, vecs[i].ft);
    end

    // Minimum dwell instance: held in reset so far, then a 4-cycle period 10,11,01,11.
    checkOutput("minReset", control2, s2, blank2, frame_tick2, 2'b11, 4'h0, 1'b1, 1'b0);
    sA     = 4'hC;
    sB     = 4'hD;
    reset2 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      case (k % 4)
        0:       begin eCtl = 2'b10; eS = 4'hC; end
        1:       begin eCtl = 2'b11; eS = 4'h0; end
        2:       begin eCtl = 2'b01; eS = 4'hD; end
        default: begin eCtl = 2'b11; eS = 4'h0; end
      endcase
      checkOutput($sformatf("minCycle%0d", k), control2, s2, blank2, frame_tick2,
                  eCtl, eS, (k % 2 == 1), (k % 4 == 0));
    end

    // Random inputs on both instances: anodes never both on, blank tracks control.
    for (int c = 0; c < 1000; c++) begin
      sA = 4'($urandom_range(0, 15));
      sB = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      checkValue("ctlNotZero", int'(control != 2'b00), 1);
      checkValue("blankMatch", int'(blank), int'(control == 2'b11));
      checkValue("minCtlNotZero", int'(control2 != 2'b00), 1);
      checkValue("minBlankMatch", int'(blank2), int'(control2 == 2'b11));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexed scan controller for the dual common-anode seven-segment display. Sits directly downstream of the switch inputs and upstream of `seven_seg_disp`. It replaces the free-running enable toggle with a four-state scan that inserts an all-off dead time between digits to suppress ghosting. Both digit values are sampled once per frame so a digit never changes while it is lit.

## Interface
Parameters:
- `ON_CYCLES`, default 99000: clock cycles each digit is lit. Must be ≥1.
- `BLANK_CYCLES`, default 1000: clock cycles of all-off dead time after each digit. Must be ≥1.

Ports:
- `clk` in 1: single clock (48 MHz HSOSC in the top level).
- `reset` in 1: synchronous, active-low reset, sampled on `posedge clk`.
- `sA` in 4: digit value for display A.
- `sB` in 4: digit value for display B.
- `s` out 4: nibble to the seven-segment encoder.
- `control` out 2: PNP anode drive, active-low. `control[0]` drives display A; `control[1]` drives display B.
- `blank` out 1: high while no digit is lit.
- `frame_tick` out 1: one-cycle pulse on the first cycle of each frame.

## Operation
- States: `DIG0`, `BLANK0`, `DIG1`, `BLANK1`, cycling in that order. There are no other transitions except reset.
- Dwell counter `cnt`:
  - Width is `$clog2(max(ON_CYCLES, BLANK_CYCLES))`, minimum 1.
  - Counts 0..N-1 in each state, where N = `ON_CYCLES` for `DIG*` and `BLANK_CYCLES` for `BLANK*`.
  - On the edge where `cnt == N-1`, the state advances and `cnt` returns to 0. Otherwise `cnt` increments.
- Digit capture: `digA_q` and `digB_q` load `sA` and `sB` only on the edge that moves `BLANK1` to `DIG0`. They hold for the whole frame.
- Outputs are pure decode of registered state and capture registers. There is no combinational path from `sA`/`sB` to any output.
  - `DIG0`: `control`=2'b10, `s`=`digA_q`, `blank`=0.
  - `DIG1`: `control`=2'b01, `s`=`digB_q`, `blank`=0.
  - `BLANK0` / `BLANK1`: `control`=2'b11, `s`=4'h0, `blank`=1.
  - `frame_tick`=1 only when state is `DIG0` and `cnt`==0.
- Both displays are never on simultaneously. `control`=2'b00 is illegal and must never occur.

## Timing
- Reset state (`reset`=0 at an edge), effective on that edge:
  - State is `BLANK1` and `cnt`=0.
  - `digA_q`=`digB_q`=0.
  - Outputs: `control`=2'b11, `s`=0, `blank`=1, `frame_tick`=0.
- First edge with `reset`=1 is edge 0. The block stays in `BLANK1` for `BLANK_CYCLES` cycles.
  - `DIG0` becomes visible after edge `BLANK_CYCLES`-1.
  - The values captured are `sA`/`sB` as sampled at that edge.
- Frame period is 2·(`ON_CYCLES`+`BLANK_CYCLES`) cycles. With the defaults this is 200000 cycles, i.e. 240 Hz frame and 480 Hz per-digit slot.
- Input changes mid-frame are ignored until the next `BLANK1`→`DIG0` edge. Latency from input change to display is at most one frame plus one cycle.
- Reset asserted mid-state, including mid-`DIG*`, forces the reset state on that same edge. The anodes turn off immediately with no partial dwell carried over.
- With `BLANK_CYCLES`=1 the dead time is exactly one cycle. With `ON_CYCLES`=1 each digit is lit exactly one cycle. The state never stalls.

## Test plan
Use `ON_CYCLES`=4 and `BLANK_CYCLES`=2 for all cases.
- Reset: hold `reset`=0 for 3 edges with `sA`=4'h5, `sB`=4'hA. Required: `control`=2'b11, `s`=0, `blank`=1, `frame_tick`=0 throughout.
- First frame: release reset. Required:
  - 2 cycles of blank.
  - `frame_tick`=1 for exactly one cycle.
  - 4 cycles with `control`=2'b10, `s`=4'h5.
  - 2 blank cycles.
  - 4 cycles with `control`=2'b01, `s`=4'hA.
  - 2 blank cycles. Period is 12.
- Tear-free capture: change `sA` to 4'h3 in the second cycle of `DIG0`. Required: `s` stays 4'h5 for the rest of that frame and shows 4'h3 in the next `DIG0`.
- Mutual exclusion: run 1000 cycles with random `sA`/`sB`. Required: `control` never equals 2'b00, and `blank`==1 exactly when `control`==2'b11.
- Mid-operation reset: assert `reset` for 1 edge in the third cycle of `DIG1`. Required: `control`=2'b11 from that edge, then a full 2-cycle `BLANK1` before `DIG0`, with the digits recaptured.
- Boundary: set `ON_CYCLES`=1 and `BLANK_CYCLES`=1. Required: a 4-cycle period with the sequence 10, 11, 01, 11, and `frame_tick` every 4th cycle.
